core_ctrl_seq: RTL and testbench
================================

# core_ctrl_seq

Hardware instruction sequencer that drives the 34-bit `inst` bus of `core` for one full convolution pass: 9 kernel positions (kij) × (weight L0 fill, PE load, activation L0 fill, execute, OFIFO drain to pmem). It sits beside `core` and replaces the bench-driven instruction stream so the array runs autonomously after a single `start` pulse. Accumulation/readback from pmem is out of scope; that is handled by a separate block.

## Interface
Parameters
- `row`, 8, PE rows
- `col`, 8, PE columns
- `len_nij`, 36, activation vectors per kij
- `len_kij`, 9, kernel positions per pass
- `w_base`, 11'h400, xmem base of kernel 0; kernel k at `w_base + k*2*col`
- `settle`, 10, idle cycles after PE load (`col+2`)
- `l0_wait_max`, 10, max cycles waiting for L0 after weight fill

Ports
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a pass when idle
- `mode`  in  1  0 = 4-bit, 1 = 2-bit; sampled on accepted `start`
- `l0_inst`  in  2  from core; bit0 = full, bit1 = ready
- `ofifo_valid`  in  1  from core
- `inst`  out  34  to core: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- `l0_version`  out  1  0 = weight bank, 1 = activation bank
- `mode_q`  out  1  latched mode, to core `mode`
- `kij`  out  4  current kernel index
- `busy`  out  1  high from accepted `start` to `done`
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- All outputs registered. Idle word: CEN_pmem=WEN_pmem=CEN_xmem=WEN_xmem=1, all other bits 0 → `inst = 34'h1_800C_0000`. acc, ififo_wr, ififo_rd always 0.
- States: IDLE → W_L0 → L0_WAIT → LOAD → SETTLE → A_L0 → EXEC → DRAIN → OF_RD → NEXT → (W_L0 if kij<len_kij-1, else DONE) → IDLE.
- IDLE: idle word; `start` latches `mode_q`, clears `kij` and the pmem address counter.
- W_L0 (l0_version=0): 2*col reads, CEN_xmem=0, WEN_xmem=1, A_xmem = `w_base + kij*2*col + j`, j=0..2*col-1; l0_wr asserted one cycle behind each read (xmem latency 1), so the state lasts 2*col+1 cycles. In 4-bit mode memory holds the 8 words duplicated; the sequencer is mode-agnostic.
- L0_WAIT: idle word; exit when `l0_inst[0]`=1 or after `l0_wait_max` cycles, whichever first; minimum 1 cycle.
- LOAD (l0_version=0): 2 cycles with l0_rd=1, load=1.
- SETTLE: `settle` idle cycles.
- A_L0 (l0_version=1): len_nij reads at A_xmem 0..len_nij-1, l0_wr one cycle behind; len_nij+1 cycles.
- EXEC (l0_version=1): len_nij cycles with l0_rd=1, execute=1.
- DRAIN: idle word until `ofifo_valid`=1.
- OF_RD: len_nij cycles with ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = `kij*len_nij + i`.
- NEXT: 1 idle cycle; increments `kij`.
- DONE: `done`=1 for one cycle, `busy` drops the same cycle, then IDLE.

## Timing
- Reset: state IDLE, `inst` = idle word, `l0_version`=0, `mode_q`=0, `kij`=0, `busy`=0, `done`=0; takes effect asynchronously, so reset mid-pass abandons the pass and returns the idle word immediately.
- `start` → first W_L0 word on `inst`: 1 cycle. `start` while busy is ignored; `mode` changes while busy do not affect `mode_q`.
- Per-kij length with immediate L0 and OFIFO: 17+1+2+10+37+36+1+36+1 = 141 cycles at defaults.
- `l0_version` changes only in IDLE-word cycles (SETTLE→A_L0 edge and NEXT→W_L0 edge), never alongside l0_rd/l0_wr.
- Addresses wrap at 11 bits; defaults never reach wrap (max A_pmem 323, max A_xmem 0x48F).

## Test plan
- Reset: hold reset_n=0 → `inst`=34'h1_800C_0000, busy=0, done=0; release without start → unchanged for 100 cycles.
- Single pass, `l0_inst[0]` tied 1, ofifo_valid tied 1, mode=1 → kij=0 W_L0 A_xmem 0x400..0x40F with l0_wr lagging 1 cycle; kij=8 uses 0x480..0x48F; pmem writes 0..323 each once; done pulses after 9×141 = 1269 cycles; mode_q=1 throughout.
- L0 timeout: `l0_inst[0]`=0 → L0_WAIT lasts exactly 10 cycles; asserting it on cycle 3 → exits after 3 cycles.
- DRAIN stall: hold ofifo_valid=0 for 50 cycles after EXEC → idle word held 50 cycles, ofifo_rd stays 0 until valid.
- Start while busy and mode toggling mid-pass → no restart, kij sequence unaffected, mode_q holds sampled value.
- Reset_n pulse during EXEC of kij=4 → inst returns to idle word asynchronously, kij=0; a new start runs a full clean pass.

Source files
------------

// File: rtl/core_ctrl_seq.sv
// core_ctrl_seq: autonomous instruction sequencer for one convolution pass of
// `core`. After a `start` pulse it walks every kernel position (kij). For each
// kij it runs, in order: weight L0 fill, PE load, settle, activation L0 fill,
// execute, OFIFO drain, and then OFIFO-to-pmem writes. Every output is registered.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   start, mode     one-cycle start pulse; mode (0=4b, 1=2b) is sampled on start
//   l0_inst[1:0]    from core: bit0 = L0 full, bit1 = ready (not needed here)
//   ofifo_valid     from core: OFIFO has data to drain
//   inst[33:0]      instruction word to core
//   l0_version      0 = weight bank, 1 = activation bank
//   mode_q          latched mode
//   kij             current kernel index
//   busy, done      busy from accepted start until done; done is a 1-cycle pulse
module core_ctrl_seq #(
  parameter int          row         = 8,
  parameter int          col         = 8,
  parameter int          len_nij     = 36,
  parameter int          len_kij     = 9,
  parameter logic [10:0] w_base      = 11'h400,
  parameter int          settle      = 10,
  parameter int          l0_wait_max = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mode,
  input  logic [1:0]  l0_inst,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        l0_version,
  output logic        mode_q,
  output logic [3:0]  kij,
  output logic        busy,
  output logic        done
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  // wide enough for the longest counted phase
  localparam int CW = $clog2(len_nij + 2*col + settle + l0_wait_max + 2) + 1;

  localparam logic [CW-1:0] C_WL0   = CW'(2*col);
  localparam logic [CW-1:0] C_WAIT  = CW'(l0_wait_max - 1);
  localparam logic [CW-1:0] C_LOAD  = CW'(1);
  localparam logic [CW-1:0] C_SET   = CW'(settle - 1);
  localparam logic [CW-1:0] C_AL0   = CW'(len_nij);
  localparam logic [CW-1:0] C_RUN   = CW'(len_nij - 1);
  localparam logic [3:0]    K_LAST  = 4'(len_kij - 1);
  localparam logic [10:0]   W_STEP  = 11'(2*col);

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_L0WAIT, S_LOAD, S_SETTLE, S_AL0,
    S_EXEC, S_DRAIN, S_OFRD, S_NEXT, S_DONE
  } state_t;

  state_t        st, ns;
  logic [CW-1:0] cnt, nc;      // cycle index within the current state
  logic [10:0]   pa, pa_d;     // next pmem write address
  logic [3:0]    kij_d;
  logic          mode_d, ver_d, busy_d, done_d;
  logic [33:0]   inst_d;

  logic unused_ok;
  assign unused_ok = ^{l0_inst[1], 32'(row)};

  // Next state and counters
  always_comb begin
    ns     = st;
    nc     = cnt + 1'b1;
    kij_d  = kij;
    pa_d   = pa;
    mode_d = mode_q;
    unique case (st)
      S_IDLE: begin
        nc = '0;
        if (start) begin
          ns     = S_WL0;
          kij_d  = '0;
          pa_d   = '0;
          mode_d = mode;
        end
      end
      S_WL0:    if (cnt == C_WL0) ns = S_L0WAIT;
      S_L0WAIT: if (l0_inst[0] || cnt == C_WAIT) ns = S_LOAD;
      S_LOAD:   if (cnt == C_LOAD) ns = S_SETTLE;
      S_SETTLE: if (cnt == C_SET) ns = S_AL0;
      S_AL0:    if (cnt == C_AL0) ns = S_EXEC;
      S_EXEC:   if (cnt == C_RUN) ns = S_DRAIN;
      S_DRAIN:  if (ofifo_valid) ns = S_OFRD;
      S_OFRD:   if (cnt == C_RUN) ns = S_NEXT;
      S_NEXT: begin
        if (kij == K_LAST) ns = S_DONE;
        else begin
          ns    = S_WL0;
          kij_d = kij + 4'd1;
        end
      end
      S_DONE:   ns = S_IDLE;
      default:  ns = S_IDLE;
    endcase
    if (ns != st) nc = '0;
    // pmem address advances after each write issued
    if (ns == S_OFRD) pa_d = pa + 11'd1;
  end

  // Output word for the state being entered, so it appears with that state
  always_comb begin
    inst_d = IDLE_WORD;
    ver_d  = 1'b0;
    busy_d = (ns != S_IDLE) && (ns != S_DONE);
    done_d = (ns == S_DONE);
    case (ns)
      S_WL0: begin
        if (nc < C_WL0) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = w_base + 11'(kij_d) * W_STEP + 11'(nc);
        end
        // xmem data arrives one cycle after the read
        if (nc != '0) inst_d[2] = 1'b1;
      end
      S_LOAD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      S_AL0: begin
        ver_d = 1'b1;
        if (nc < C_AL0) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(nc);
        end
        if (nc != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        ver_d     = 1'b1;
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_DRAIN, S_NEXT: ver_d = 1'b1;
      S_OFRD: begin
        ver_d         = 1'b1;
        inst_d[32]    = 1'b0;
        inst_d[31]    = 1'b0;
        inst_d[30:20] = pa;
        inst_d[6]     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      cnt        <= '0;
      pa         <= '0;
      kij        <= '0;
      mode_q     <= 1'b0;
      inst       <= IDLE_WORD;
      l0_version <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      st         <= ns;
      cnt        <= nc;
      pa         <= pa_d;
      kij        <= kij_d;
      mode_q     <= mode_d;
      inst       <= inst_d;
      l0_version <= ver_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Self-checking bench for core_ctrl_seq. A reset/start vector table is
// followed by full passes. In each pass a procedural per-phase model predicts
// every output cycle by cycle, and it also picks the L0-full and OFIFO-valid
// timing. Inputs the sequencer should ignore are driven with random noise.
module tb_core_ctrl_seq;

  localparam logic [33:0] IDLE_W  = 34'h1_800C_0000;
  localparam int          NIJ     = 36;
  localparam int          NK      = 9;
  localparam int          WN      = 16;   // 2*col weight reads
  localparam int          SETTLE  = 10;
  localparam int          WAITMAX = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  l0_inst = 2'b00;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        l0_version, mode_q, busy, done;
  logic [3:0]  kij;

  always #5 clk = ~clk;

  core_ctrl_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .l0_inst(l0_inst), .ofifo_valid(ofifo_valid), .inst(inst),
    .l0_version(l0_version), .mode_q(mode_q), .kij(kij),
    .busy(busy), .done(done)
  );

  int         n_checks = 0;
  int         n_err = 0;
  int         scen = 0;
  bit         noise_start = 1'b0;
  logic       nx_full = 1'b0, nx_valid = 1'b0, nx_start = 1'b0, nx_mode = 1'b0;
  logic       exp_mode = 1'b0;
  logic [3:0] exp_kij = 4'd0;
  int         ncyc = 0;
  int         pm_hits[2048];
  int         pm_total = 0;

  typedef struct {
    logic        rst_n, st, md, full, vld;
    logic [33:0] w;
    logic        bz, mq;
  } vec_t;
  vec_t tv[8];

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [41:0] pk(logic [33:0] w, logic v, logic m,
                                     logic [3:0] k, logic b, logic d);
    return {w, v, m, k, b, d};
  endfunction

  task automatic chk(input string nm, input logic [41:0] got, input logic [41:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got inst=%h ver=%b mq=%b kij=%0d busy=%b done=%b, want inst=%h ver=%b mq=%b kij=%0d busy=%b done=%b",
               nm, $time, got[41:8], got[7], got[6], got[5:2], got[1], got[0],
               exp[41:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic logic [41:0] act();
    return pk(inst, l0_version, mode_q, kij, busy, done);
  endfunction

  // Check this cycle, then drive inputs and advance one clock
  task automatic cyc(input string nm, input logic [33:0] w, input logic v,
                     input logic [3:0] k, input logic b, input logic d);
    chk(nm, act(), pk(w, v, exp_mode, k, b, d));
    if (inst[32:31] == 2'b00) begin
      pm_hits[inst[30:20]]++;
      pm_total++;
    end
    l0_inst     = {rb(), nx_full};
    ofifo_valid = nx_valid;
    start       = nx_start;
    mode        = nx_mode;
    @(posedge clk); #1;
    ncyc++;
    nx_full  = rb();
    nx_valid = rb();
    nx_start = noise_start ? rb() : 1'b0;
    nx_mode  = rb();
  endtask

  function automatic logic pick_full(int k, int n);
    if (scen == 0) return 1'b1;
    if (k == 0) return 1'b0;            // full never comes: timeout path
    if (k == 1) return (n == 2);        // full on the third wait cycle
    return rb() | (n >= 5);
  endfunction

  function automatic logic pick_valid(int k, int n);
    if (scen == 0) return 1'b1;
    if (k == 3) return (n == 49);       // 50-cycle drain stall
    return rb() | (n >= 4);
  endfunction

  task automatic clear_pm();
    for (int a = 0; a < 2048; a++) pm_hits[a] = 0;
    pm_total = 0;
  endtask

  task automatic check_pm();
    int once;
    once = 0;
    for (int a = 0; a < NK*NIJ; a++) if (pm_hits[a] == 1) once++;
    chk_int("pmem_once", once, NK*NIJ);
    chk_int("pmem_total", pm_total, NK*NIJ);
  endtask

  task automatic run_pass(input logic m, input int abort_k);
    logic [33:0] w;
    logic f, v;
    nx_start = 1'b1;
    nx_mode  = m;
    cyc("idle_start", IDLE_W, 1'b0, exp_kij, 1'b0, 1'b0);
    exp_mode = m;
    ncyc = 0;
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j <= WN; j++) begin
        w = IDLE_W;
        if (j < WN) begin
          w[19]   = 1'b0;
          w[17:7] = 11'h400 + 11'(k*WN + j);
        end
        if (j > 0) w[2] = 1'b1;
        cyc("w_l0", w, 1'b0, 4'(k), 1'b1, 1'b0);
      end
      for (int n = 0; n < WAITMAX; n++) begin
        f = pick_full(k, n);
        nx_full = f;
        cyc("l0_wait", IDLE_W, 1'b0, 4'(k), 1'b1, 1'b0);
        if (f) break;
      end
      for (int j = 0; j < 2; j++) begin
        w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
        cyc("load", w, 1'b0, 4'(k), 1'b1, 1'b0);
      end
      for (int j = 0; j < SETTLE; j++)
        cyc("settle", IDLE_W, 1'b0, 4'(k), 1'b1, 1'b0);
      for (int j = 0; j <= NIJ; j++) begin
        w = IDLE_W;
        if (j < NIJ) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(j);
        end
        if (j > 0) w[2] = 1'b1;
        cyc("a_l0", w, 1'b1, 4'(k), 1'b1, 1'b0);
      end
      for (int j = 0; j < NIJ; j++) begin
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
        if (k == abort_k && j == 10) begin
          chk("exec_pre_rst", act(), pk(w, 1'b1, exp_mode, 4'(k), 1'b1, 1'b0));
          #2 reset_n = 1'b0;
          start = 1'b0;
          #1;
          chk("async_rst", act(), pk(IDLE_W, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
          @(negedge clk);
          reset_n = 1'b1;
          @(posedge clk); #1;
          exp_mode = 1'b0;
          exp_kij  = 4'd0;
          chk("post_rst_idle", act(), pk(IDLE_W, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
          nx_start = 1'b0;
          return;
        end
        cyc("exec", w, 1'b1, 4'(k), 1'b1, 1'b0);
      end
      for (int n = 0; n < 1000; n++) begin
        v = pick_valid(k, n);
        nx_valid = v;
        cyc("drain", IDLE_W, 1'b1, 4'(k), 1'b1, 1'b0);
        if (v) break;
      end
      for (int i = 0; i < NIJ; i++) begin
        w = IDLE_W;
        w[32] = 1'b0; w[31] = 1'b0;
        w[30:20] = 11'(k*NIJ + i);
        w[6] = 1'b1;
        cyc("of_rd", w, 1'b1, 4'(k), 1'b1, 1'b0);
      end
      cyc("next", IDLE_W, 1'b1, 4'(k), 1'b1, 1'b0);
    end
    if (scen == 0) chk_int("pass_len", ncyc, NK*141);
    cyc("done", IDLE_W, 1'b0, 4'(NK-1), 1'b0, 1'b1);
    nx_start = 1'b0;
    exp_kij  = 4'(NK-1);
    chk("idle_after", act(), pk(IDLE_W, 1'b0, exp_mode, exp_kij, 1'b0, 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            rst st md fu vl  inst             bz mq
    tv[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, IDLE_W,           1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, IDLE_W,           1'b0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IDLE_W,           1'b0, 1'b0};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 34'h1_8006_0000,  1'b1, 1'b1};
    tv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 34'h1_8006_0084,  1'b1, 1'b1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 34'h1_8006_0104,  1'b1, 1'b1};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      reset_n     = tv[i].rst_n;
      start       = tv[i].st;
      mode        = tv[i].md;
      l0_inst     = {1'b0, tv[i].full};
      ofifo_valid = tv[i].vld;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), act(),
          pk(tv[i].w, 1'b0, tv[i].mq, 4'd0, tv[i].bz, 1'b0));
    end

    reset_n = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      mode = rb(); l0_inst = {rb(), rb()}; ofifo_valid = rb();
      @(posedge clk); #1;
      chk("idle_hold", act(), pk(IDLE_W, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    end

    // L0 full and OFIFO valid always present, mode=1
    scen = 0; noise_start = 1'b0;
    clear_pm();
    run_pass(1'b1, -1);
    check_pm();

    // L0 timeout, late full, drain stall, starts while busy, mode toggling
    scen = 1; noise_start = 1'b1;
    run_pass(1'b0, -1);

    // Reset during EXEC of kij=4, then a clean pass
    run_pass(1'b1, 4);
    scen = 0; noise_start = 1'b0;
    clear_pm();
    run_pass(1'b0, -1);
    check_pm();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
